pulse_separator_core: RTL and testbench
=======================================

Name: pulse_separator_core

Overview:
- Converts arbitrary input pulse activity into a train of one-cycle output pulses, each separated by at least one low cycle.
- Every input cycle with pulse_in high counts as one event, so a long pulse or back-to-back pulses produce one output pulse per high cycle.
- Used in front of edge/pulse consumers that need one clean, separated pulse per event. An internal pending counter buffers the events, and busy signals that this counter is full.

Parameters:
- PULSE_COUNTER_WIDTH, default 3: width of the pending-event counter; maximum pending count is 2^PULSE_COUNTER_WIDTH-1.

Ports:
- clock  input  1  single clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pulse_in  input  1  event input; each cycle sampled high is one event.
- pulse_out  output  1  registered; one-cycle pulses, never high two consecutive cycles.
- busy  output  1  high when the pending counter is at its maximum and further events may be lost.

Behaviour:
- State:
  - pending: unsigned counter, PULSE_COUNTER_WIDTH bits.
  - pulse_out_q: the pulse_out register.
- Reset (asynchronous, active-high): pending=0, pulse_out=0, busy=0. Reset mid-operation discards all pending events immediately.
- emit = ~pulse_out_q & (pulse_in | pending != 0). Combinational; this is the decision to fire next cycle.
- On each rising edge:
  - pulse_out_q <= emit.
  - pending <= pending + pulse_in - emit, with saturation.
  - If pending == max, pulse_in=1 and emit=0: pending stays at max, and the event is dropped.
  - If pending == max, pulse_in=1 and emit=1: the net change is zero, so the event is accepted.
  - pending never underflows, because emit=1 with pending=0 requires pulse_in=1.
- Latency: an event arriving while idle produces pulse_out high on the cycle after pulse_in is sampled (1 cycle).
- Spacing:
  - pulse_out is high exactly one cycle, then low at least one cycle.
  - While events are pending, the pattern is strictly alternating 1,0,1,0.
- busy = (pending == 2^PULSE_COUNTER_WIDTH-1). It is decoded from registered state only, so it is glitch-free and has no combinational path from pulse_in.
- Idle condition: pending==0 and pulse_out==0. The output then stays low until pulse_in rises.
- Event conservation: the number of pulse_out pulses equals the number of accepted pulse_in high cycles. No spurious pulses occur.

Decomposition:
- No shared package is needed; the only constant (counter maximum) is derived locally from the parameter.
- No sub-module is needed. The saturating up/down counter may optionally be a small generic sub-module, saturating_updown_counter, but inline RTL is preferred.

Test Plan:
- Single pulse: pulse_in high 1 cycle after reset -> exactly 1 pulse_out pulse, 1 cycle after input; output low afterwards; busy stays 0.
- Long pulse: pulse_in high 4 consecutive cycles -> exactly 4 pulses in pattern 1,0,1,0,1,0,1, first pulse 1 cycle after input rise; output low at end.
- Multiple pulses: 4 repetitions of (pulse_in 1 cycle high, 1 cycle low) -> exactly 4 pulses, each 1 cycle wide, separated by exactly 1 low cycle.
- Saturation (W=3):
  - Hold pulse_in high until busy is seen -> busy rises after 14 accepted input cycles (pending reaches 7).
  - After pulse_in drops -> exactly 14 output pulses total, then pulse_out stays 0 and busy returns to 0.
- Random: ~100 cycles of random pulse_in, gated off whenever busy=1 -> output pulses equal accepted input-high cycles; no output pulse wider than 1 cycle.
- Async reset: assert reset mid-burst with pending>0 -> pulse_out and busy go 0 immediately, without waiting for a clock edge; no pulses after reset release until new input.

Source files
------------

// File: rtl/pulse_separator_core.sv
// rtl/pulse_separator_core.sv - turns arbitrary pulse_in activity into separated one-cycle pulses
// Each high input cycle is one event; a saturating pending counter buffers events between pulses.
module pulse_separator_core #(
  parameter int PULSE_COUNTER_WIDTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic pulse_in,
  output logic pulse_out,
  output logic busy
);

  localparam logic [PULSE_COUNTER_WIDTH-1:0] PENDING_MAX = '1;

  logic [PULSE_COUNTER_WIDTH-1:0] pending;
  logic                           pulse_out_q;
  logic                           emit;

  // Fire whenever the previous cycle was low and there is any event to serve.
  assign emit = ~pulse_out_q & (pulse_in | (pending != '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      pulse_out_q <= 1'b0;
    end else begin
      pulse_out_q <= emit;
      unique case ({pulse_in, emit})
        2'b10: begin
          // At the maximum the incoming event is dropped.
          if (pending != PENDING_MAX) begin
            pending <= pending + 1'b1;
          end
        end
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  assign pulse_out = pulse_out_q;
  assign busy      = (pending == PENDING_MAX);

endmodule

// File: tb/tb_pulse_separator_core.sv
// tb/tb_pulse_separator_core.sv - directed self-checking bench for pulse_separator_core
module tb_pulse_separator_core;

  logic clock;
  logic reset;
  logic pulse_in;
  logic pulse_out;
  logic busy;

  int vectors;
  int miscompares;
  int pulse_cnt;
  int wide_cnt;
  int accepted;
  logic prev_out;
  logic r;

  pulse_separator_core #(.PULSE_COUNTER_WIDTH(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .pulse_in  (pulse_in),
    .pulse_out (pulse_out),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one input cycle and sample just after the rising edge.
  task automatic tick(input logic p);
    pulse_in = p;
    @(posedge clock);
    #1;
    if (pulse_out === 1'b1) pulse_cnt++;
    if (pulse_out === 1'b1 && prev_out === 1'b1) wide_cnt++;
    prev_out = pulse_out;
  endtask

  task automatic vec(input string tag, input logic p, input logic exp_out, input logic exp_busy);
    tick(p);
    chk({tag, "_out"}, int'(pulse_out), int'(exp_out));
    chk({tag, "_busy"}, int'(busy), int'(exp_busy));
  endtask

  task automatic fill_to_busy(input string tag);
    accepted = 0;
    for (int i = 0; i < 40 && busy !== 1'b1; i++) begin
      tick(1'b1);
      accepted++;
    end
    chk({tag, "_accepted"}, accepted, 14);
    chk({tag, "_busy"}, int'(busy), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) tick(1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pulse_cnt   = 0;
    wide_cnt    = 0;
    prev_out    = 1'b0;
    pulse_in    = 1'b0;
    reset       = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    chk("reset_out", int'(pulse_out), 0);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;

    // Single pulse: output follows one cycle later, then stays low.
    vec("single0", 1'b1, 1'b1, 1'b0);
    vec("single1", 1'b0, 1'b0, 1'b0);
    vec("single2", 1'b0, 1'b0, 1'b0);
    vec("single3", 1'b0, 1'b0, 1'b0);

    // Long pulse of four cycles gives 1,0,1,0,1,0,1,0.
    vec("long0", 1'b1, 1'b1, 1'b0);
    vec("long1", 1'b1, 1'b0, 1'b0);
    vec("long2", 1'b1, 1'b1, 1'b0);
    vec("long3", 1'b1, 1'b0, 1'b0);
    vec("long4", 1'b0, 1'b1, 1'b0);
    vec("long5", 1'b0, 1'b0, 1'b0);
    vec("long6", 1'b0, 1'b1, 1'b0);
    vec("long7", 1'b0, 1'b0, 1'b0);
    vec("long8", 1'b0, 1'b0, 1'b0);

    // Separated input pulses pass straight through.
    for (int i = 0; i < 4; i++) begin
      vec($sformatf("multi%0d_hi", i), 1'b1, 1'b1, 1'b0);
      vec($sformatf("multi%0d_lo", i), 1'b0, 1'b0, 1'b0);
    end
    drain();

    // Saturation: 14 accepted cycles fill the counter, 14 pulses drain it.
    pulse_cnt = 0;
    wide_cnt  = 0;
    fill_to_busy("sat");
    drain();
    chk("sat_pulses", pulse_cnt, 14);
    chk("sat_wide", wide_cnt, 0);
    chk("sat_end_out", int'(pulse_out), 0);
    chk("sat_end_busy", int'(busy), 0);

    // At max: an event coinciding with emit is accepted, one without is dropped.
    pulse_cnt = 0;
    fill_to_busy("sat2");
    vec("sat2_accept", 1'b1, 1'b1, 1'b1);
    vec("sat2_drop", 1'b1, 1'b0, 1'b1);
    drain();
    chk("sat2_pulses", pulse_cnt, 15);
    chk("sat2_end_busy", int'(busy), 0);

    // Random traffic gated by busy keeps events conserved.
    pulse_cnt = 0;
    wide_cnt  = 0;
    accepted  = 0;
    for (int i = 0; i < 100; i++) begin
      r = 1'($urandom_range(0, 1)) & ~busy;
      if (r) accepted++;
      tick(r);
    end
    drain();
    chk("rand_pulses", pulse_cnt, accepted);
    chk("rand_wide", wide_cnt, 0);
    chk("rand_end_out", int'(pulse_out), 0);

    // Asynchronous reset while a pulse is out and the counter is full.
    fill_to_busy("arst");
    vec("arst_pre", 1'b1, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out", int'(pulse_out), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clock);
    reset     = 1'b0;
    pulse_cnt = 0;
    prev_out  = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b0);
    chk("arst_after_pulses", pulse_cnt, 0);
    chk("arst_after_busy", int'(busy), 0);
    vec("arst_new", 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
